// File: rtl/mem_arbiter.sv
// mem_arbiter: time-slots one single-port RAM between a CPU and a VGA reader.
// Each slot is an address cycle followed by a data cycle. VGA slots never run back to back.
module mem_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [WORD_SIZE-1:0]  cpu_addr,
    input  logic                  cpu_mem_write,
    input  logic [WORD_SIZE-1:0]  cpu_write_data,
    output logic [WORD_SIZE-1:0]  cpu_read_data,
    output logic                  cpu_pre_en,
    output logic                  cpu_en,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_ack,
    output logic [WORD_SIZE-1:0]  vga_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [WORD_SIZE-1:0]  ram_wdata,
    input  logic [WORD_SIZE-1:0]  ram_rdata,
    output logic                  oob_err,
    output logic [WORD_SIZE-1:0]  step_count
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_A,
        CPU_D,
        VGA_A,
        VGA_D
    } state_e;

    state_e               state_q, state_d;
    logic                 oob_q, oob_d;
    logic [WORD_SIZE-1:0] step_q, step_d;
    logic                 in_range;

    // CPU address fits inside the RAM when all bits above the word address are zero
    assign in_range = (cpu_addr[WORD_SIZE-1:ADDR_WIDTH] == '0);

    assign ram_wdata  = cpu_write_data;
    assign oob_err    = oob_q;
    assign step_count = step_q;

    // Next state, slot outputs, and sticky error / slot counter updates
    always_comb begin
        state_d       = state_q;
        ram_addr      = '0;
        ram_we        = 1'b0;
        cpu_pre_en    = 1'b0;
        cpu_en        = 1'b0;
        cpu_read_data = '0;
        vga_ack       = 1'b0;
        vga_rdata     = '0;
        oob_d         = oob_q;
        step_d        = step_q;
        unique case (state_q)
            IDLE: begin
                if (vga_req) begin
                    state_d = VGA_A;
                end else if (run) begin
                    state_d = CPU_A;
                end
            end
            CPU_A: begin
                ram_addr   = cpu_addr[ADDR_WIDTH-1:0];
                cpu_pre_en = 1'b1;
                state_d    = CPU_D;
            end
            CPU_D: begin
                ram_addr = cpu_addr[ADDR_WIDTH-1:0];
                cpu_en   = 1'b1;
                step_d   = step_q + WORD_SIZE'(1);
                if (in_range) begin
                    cpu_read_data = ram_rdata;
                    ram_we        = cpu_mem_write;
                end else begin
                    oob_d = 1'b1;
                end
                if (vga_req) begin
                    state_d = VGA_A;
                end else if (run) begin
                    state_d = CPU_A;
                end else begin
                    state_d = IDLE;
                end
            end
            VGA_A: begin
                ram_addr = vga_addr;
                state_d  = VGA_D;
            end
            VGA_D: begin
                ram_addr  = vga_addr;
                vga_ack   = 1'b1;
                vga_rdata = ram_rdata;
                state_d   = run ? CPU_A : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An interrupted slot must not write or signal completion
        if (reset) begin
            ram_we        = 1'b0;
            cpu_pre_en    = 1'b0;
            cpu_en        = 1'b0;
            vga_ack       = 1'b0;
            cpu_read_data = '0;
            vga_rdata     = '0;
        end
    end

    // State, sticky error flag and slot counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            oob_q   <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            oob_q   <= oob_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter slot sequencing,
// RAM access, out-of-range handling and reset behaviour.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] cpu_addr;
    logic        cpu_mem_write;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        cpu_pre_en;
    logic        cpu_en;
    logic        vga_req;
    logic [8:0]  vga_addr;
    logic        vga_ack;
    logic [31:0] vga_rdata;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        oob_err;
    logic [31:0] step_count;

    int n_assert = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int we_base;

    logic [31:0] mem [0:511];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .cpu_addr       (cpu_addr),
        .cpu_mem_write  (cpu_mem_write),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cpu_pre_en     (cpu_pre_en),
        .cpu_en         (cpu_en),
        .vga_req        (vga_req),
        .vga_addr       (vga_addr),
        .vga_ack        (vga_ack),
        .vga_rdata      (vga_rdata),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .oob_err        (oob_err),
        .step_count     (step_count)
    );

    // Synchronous RAM: read data appears one cycle after the address
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        run            = 1'b0;
        cpu_addr       = '0;
        cpu_mem_write  = 1'b0;
        cpu_write_data = '0;
        vga_req        = 1'b0;
        vga_addr       = '0;

        // reset state
        tick();
        chk("rst_pre_en", 32'(cpu_pre_en), 0);
        chk("rst_en", 32'(cpu_en), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_ack", 32'(vga_ack), 0);
        chk("rst_steps", step_count, 0);
        chk("rst_oob", 32'(oob_err), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        reset = 1'b0;
        tick();
        chk("idle_pre_en", 32'(cpu_pre_en), 0);
        chk("idle_addr", 32'(ram_addr), 0);
        run = 1'b1;

        // continuous CPU slots: A/D alternate, one count per D
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk($sformatf("alt_pre_en[%0d]", i), 32'(cpu_pre_en), 32'(i % 2 == 0));
            chk($sformatf("alt_en[%0d]", i), 32'(cpu_en), 32'(i % 2 == 1));
            chk($sformatf("alt_steps[%0d]", i), step_count, 32'(i / 2));
        end

        // run dropped in CPU_A: slot still completes, then IDLE
        run = 1'b0;
        tick();
        chk("drop_en", 32'(cpu_en), 1);
        chk("drop_steps_d", step_count, 5);
        tick();
        chk("drop_idle_en", 32'(cpu_en), 0);
        chk("drop_idle_pre", 32'(cpu_pre_en), 0);
        chk("drop_steps", step_count, 6);
        tick();
        chk("drop_stay_pre", 32'(cpu_pre_en), 0);

        // store 0xDEADBEEF to 485 then VGA reads it back
        we_base        = we_cnt;
        cpu_addr       = 32'd485;
        cpu_mem_write  = 1'b1;
        cpu_write_data = 32'hDEADBEEF;
        run            = 1'b1;
        tick();
        chk("st_pre_en", 32'(cpu_pre_en), 1);
        chk("st_addr_a", 32'(ram_addr), 485);
        chk("st_we_a", 32'(ram_we), 0);
        run = 1'b0;
        tick();
        chk("st_we_d", 32'(ram_we), 1);
        chk("st_wdata", ram_wdata, 32'hDEADBEEF);
        chk("st_en", 32'(cpu_en), 1);
        vga_req  = 1'b1;
        vga_addr = 9'd485;
        tick();
        cpu_mem_write = 1'b0;
        chk("vga_a_addr", 32'(ram_addr), 485);
        chk("vga_a_ack", 32'(vga_ack), 0);
        chk("vga_a_rdata", vga_rdata, 0);
        chk("vga_a_steps", step_count, 7);
        vga_req = 1'b0;
        tick();
        chk("vga_d_ack", 32'(vga_ack), 1);
        chk("vga_d_rdata", vga_rdata, 32'hDEADBEEF);
        tick();
        chk("vga_idle_ack", 32'(vga_ack), 0);
        chk("vga_idle_rdata", vga_rdata, 0);
        chk("st_we_once", 32'(we_cnt - we_base), 1);

        // CPU read of 485 returns data in its D cycle
        run = 1'b1;
        tick();
        chk("rd_pre_en", 32'(cpu_pre_en), 1);
        chk("rd_data_a", cpu_read_data, 0);
        run = 1'b0;
        tick();
        chk("rd_data_d", cpu_read_data, 32'hDEADBEEF);
        chk("rd_we", 32'(ram_we), 0);
        tick();
        chk("rd_steps", step_count, 8);

        // out-of-range write to 600
        we_base        = we_cnt;
        cpu_addr       = 32'd600;
        cpu_mem_write  = 1'b1;
        cpu_write_data = 32'h12345678;
        run            = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("oob_en", 32'(cpu_en), 1);
        chk("oob_we", 32'(ram_we), 0);
        chk("oob_rdata", cpu_read_data, 0);
        chk("oob_flag_d", 32'(oob_err), 0);
        tick();
        chk("oob_flag", 32'(oob_err), 1);
        cpu_mem_write = 1'b0;
        cpu_addr      = '0;
        tick();
        chk("oob_sticky", 32'(oob_err), 1);
        chk("oob_no_write", 32'(we_cnt - we_base), 0);
        chk("oob_steps", step_count, 9);

        // run with vga_req held: VGA_A, VGA_D, CPU_A, CPU_D repeating
        run      = 1'b1;
        vga_req  = 1'b1;
        vga_addr = 9'd3;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk($sformatf("mix_ack[%0d]", j), 32'(vga_ack), 32'(j % 4 == 1));
            chk($sformatf("mix_pre[%0d]", j), 32'(cpu_pre_en), 32'(j % 4 == 2));
            chk($sformatf("mix_en[%0d]", j), 32'(cpu_en), 32'(j % 4 == 3));
            chk($sformatf("mix_steps[%0d]", j), step_count, 32'(9 + (j >= 4 ? 1 : 0)));
        end

        // reset during a CPU_D write: no write, state/counters cleared
        we_base       = we_cnt;
        cpu_addr      = 32'd10;
        cpu_mem_write = 1'b1;
        reset         = 1'b1;
        #1;
        chk("rstd_we", 32'(ram_we), 0);
        chk("rstd_en", 32'(cpu_en), 0);
        tick();
        reset         = 1'b0;
        run           = 1'b0;
        vga_req       = 1'b0;
        cpu_mem_write = 1'b0;
        #1;
        chk("rstd_steps", step_count, 0);
        chk("rstd_oob", 32'(oob_err), 0);
        chk("rstd_idle_addr", 32'(ram_addr), 0);
        chk("rstd_no_write", 32'(we_cnt - we_base), 0);
        tick();
        chk("rstd_stay_idle", 32'(cpu_pre_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter WORD_SIZE, default 32, as the data and CPU address width.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 9, as the RAM word-address width (512 words; VGA register mirror at 480..511).
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  permits CPU slots.
- cpu_addr  in  WORD_SIZE  CPU memory address.
- cpu_mem_write  in  1  CPU write request.
- cpu_write_data  in  WORD_SIZE  CPU store data.
- cpu_read_data  out  WORD_SIZE  data to CPU.
- cpu_pre_en  out  1  CPU address phase strobe.
- cpu_en  out  1  CPU commit strobe.
- vga_req  in  1  VGA read request, level.
- vga_addr  in  ADDR_WIDTH  VGA read address.
- vga_ack  out  1  VGA data valid, one-cycle pulse.
- vga_rdata  out  WORD_SIZE  VGA read data.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  WORD_SIZE  RAM write data.
- ram_rdata  in  WORD_SIZE  RAM read data, valid one cycle after ram_addr.
- oob_err  out  1  sticky CPU out-of-range flag.
- step_count  out  WORD_SIZE  count of completed CPU slots.

Function
REQ-004 The FSM SHALL have states IDLE, CPU_A, CPU_D, VGA_A, VGA_D.
REQ-005 IDLE SHALL go to VGA_A if vga_req=1, else to CPU_A if run=1, else stay in IDLE.
REQ-006 CPU_A SHALL always go to CPU_D; VGA_A SHALL always go to VGA_D.
REQ-007 CPU_D SHALL go to VGA_A if vga_req=1, else to CPU_A if run=1, else to IDLE.
REQ-008 VGA_D SHALL go to CPU_A if run=1, else to IDLE, so that two VGA slots are never back-to-back while run=1.
REQ-009 In CPU_A and CPU_D, ram_addr SHALL equal cpu_addr[ADDR_WIDTH-1:0]; in VGA_A and VGA_D it SHALL equal vga_addr; in IDLE it SHALL be 0.
REQ-010 cpu_pre_en SHALL be 1 only in CPU_A; cpu_en SHALL be 1 only in CPU_D.
REQ-011 cpu_read_data SHALL equal ram_rdata in CPU_D when the address is in range, and 0 otherwise.
REQ-012 ram_we SHALL be 1 only in CPU_D with cpu_mem_write=1 and cpu_addr < 2^ADDR_WIDTH; ram_wdata SHALL equal cpu_write_data.
REQ-013 In CPU_D with cpu_addr >= 2^ADDR_WIDTH: no write SHALL occur, cpu_read_data SHALL be 0, and oob_err SHALL set to 1 on the next edge and hold until reset.
REQ-014 vga_ack SHALL be 1 only in VGA_D, with vga_rdata = ram_rdata in that cycle; vga_rdata SHALL be 0 otherwise.
REQ-015 step_count SHALL increment by 1 on each edge leaving CPU_D and SHALL wrap from 2^WORD_SIZE-1 to 0.
REQ-016 Read latency SHALL be 1 cycle: data for an address presented in an A state is returned in the following D state.
REQ-017 When run deasserts mid-slot, the current CPU slot SHALL complete (CPU_D is always reached) before IDLE.
REQ-018 vga_req dropping during VGA_A SHALL NOT abort the slot; vga_ack SHALL still pulse.
REQ-019 Outputs SHALL be combinational decodes of the state register and inputs; only state, oob_err and step_count SHALL be registered.

Reset
REQ-020 With reset=1 at a rising edge, state SHALL become IDLE, oob_err 0 and step_count 0.
REQ-021 In the cycle reset is asserted, ram_we, cpu_pre_en, cpu_en and vga_ack SHALL be forced to 0, including mid-slot (an interrupted CPU_D SHALL NOT write).
REQ-022 After reset deasserts, the first slot SHALL start no earlier than the cycle after IDLE is observed.

Verification
REQ-023 Reset, then run=1, vga_req=0 -> states alternate CPU_A/CPU_D; cpu_pre_en and cpu_en each pulse every 2 cycles; step_count = 5 after 10 cycles.
REQ-024 CPU store cpu_addr=485, data 0xDEADBEEF, then a VGA read with vga_addr=485 -> ram_we high in exactly one cycle; vga_ack pulses with vga_rdata = 0xDEADBEEF.
REQ-025 run=1 with vga_req held at 1 -> strict alternation CPU_A, CPU_D, VGA_A, VGA_D; vga_ack every 4 cycles; step_count +1 per 4 cycles.
REQ-026 CPU write with cpu_addr=600 -> ram_we stays 0, cpu_read_data = 0 in CPU_D, oob_err = 1 from the next cycle until reset.
REQ-027 reset asserted during CPU_D with cpu_mem_write=1 -> ram_we = 0 in that cycle; state = IDLE, step_count = 0 next cycle.
REQ-028 run dropped during CPU_A -> CPU_D still occurs with cpu_en = 1, then IDLE; step_count increments once.
